dram_line_adapter: RTL and testbench
====================================

# dram_line_adapter

Line-to-word bridge placed directly upstream of the single-port word DRAM model. Accepts one cache-line read or write request through a valid/ready handshake and drives WORDS back-to-back single-word DRAM accesses. For reads it collects the one-cycle-latency read data into a line buffer; for writes it collects the DRAM's write-through echo. It then returns the full line on a valid/ready response port. Cache-side blocks use it so they never sequence word-wide DRAM traffic themselves.

## Interface
- DATA, 32, DRAM word width in bits.
- ADDR, 32, DRAM word-address width.
- WORDS, 4, words per line; a power of two, at least 2.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  adapter can accept a request.
- req_wr  input  1  1 = line write, 0 = line read.
- req_addr  input  ADDR  word address of the line; the low log2(WORDS) bits are ignored.
- req_data  input  DATA*WORDS  write line; word i is at bits [i*DATA +: DATA].
- resp_valid  output  1  response line present.
- resp_ready  input  1  consumer accepts the response.
- resp_wr  output  1  req_wr of the request being answered.
- resp_data  output  DATA*WORDS  line read back; same word packing as req_data.
- mem_wr  output  1  to DRAM wr.
- mem_addr  output  ADDR  to DRAM addr.
- mem_din  output  DATA  to DRAM din.
- mem_dout  input  DATA  from DRAM dout; registered in the DRAM, so valid one cycle after the address is driven.

## Operation
- Registers:
  - state: IDLE, BURST, CAPTURE, RESP.
  - base: ADDR bits, with the low log2(WORDS) bits forced to 0.
  - wr_q, the latched req_wr.
  - wbuf: the latched request line.
  - cnt: log2(WORDS) bits.
  - cap_en and cap_idx: the capture pipeline.
  - rbuf: the response line.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch base, wr_q and wbuf; set cnt=0; go to BURST.
- BURST:
  - mem_addr=base+cnt (ADDR-bit add, modulo 2^ADDR).
  - mem_wr=wr_q.
  - mem_din=wbuf word cnt.
  - Each cycle: cap_en<=1, cap_idx<=cnt, cnt<=cnt+1.
  - When cnt==WORDS-1, go to CAPTURE; cnt wraps to 0.
- Capture rule: whenever cap_en=1, rbuf word cap_idx<=mem_dout. cap_en is cleared in every state except BURST.
- CAPTURE: captures the last word (cap_idx=WORDS-1) and goes to RESP.
- RESP:
  - resp_valid=1; resp_data=rbuf and resp_wr=wr_q, both held stable.
  - On resp_ready, go to IDLE.
- For writes, rbuf ends up equal to wbuf, because the DRAM echoes din on dout during a write.
- Outside BURST:
  - mem_wr=0.
  - mem_addr and mem_din continue to present base+cnt and wbuf word cnt. The DRAM read this causes is harmless.
- Requests are never reordered and never overlap; only one is outstanding at a time.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_wr=0, resp_data=0, mem_wr=0, mem_addr=0, mem_din=0. cnt, cap_en, base, wr_q, wbuf and rbuf are all cleared.
- Latency: if the request is accepted at edge e0, beat i drives the DRAM in the cycle after edge e(i), for i=0..WORDS-1. resp_valid rises after edge e(WORDS+1). With WORDS=4 that is 5 edges.
- Throughput: at least WORDS+3 cycles per request. This includes one IDLE bubble after the response handshake; req_ready is never high in the same cycle as resp_valid.
- resp_valid stalls indefinitely while resp_ready=0, with resp_data and resp_wr held.
- req_valid asserted outside IDLE is ignored (req_ready=0).
- Reset mid-BURST:
  - Return to IDLE immediately and asynchronously.
  - mem_wr drops asynchronously; no response is produced.
  - Words already written stay written.
- Reset during RESP: the response is discarded.

## Test plan
- Read: DRAM preloaded with mem[k]=0xA0000000+k. Read at req_addr=0x0000000B (base 8). Required: resp_data = {0xA000000B,0xA000000A,0xA0000009,0xA0000008} (MSW first), resp_wr=0, resp_valid 5 edges after acceptance.
- Write then read: write addr 0x10 with line {0xDEAD0003,0xDEAD0002,0xDEAD0001,0xDEAD0000}. Required: mem_wr high for exactly 4 cycles at addresses 0x10..0x13; the response echoes the line with resp_wr=1. A following read of 0x10 returns the same line.
- Backpressure: hold resp_ready=0 for 10 cycles during a read response. Required: resp_valid, resp_data and resp_wr stay stable and req_ready stays 0. After the handshake, req_ready=1 on the next cycle.
- Back-to-back: req_valid held high with two requests (read 0x20, then write 0x24). Required: the second is accepted only after the first response handshake plus one IDLE cycle; no overlapping mem_wr.
- Reset mid-write: assert reset during beat 2 of a write to 0x30. Required: mem_wr=0 and resp_valid=0 immediately, req_ready=1. Afterwards mem[0x30],mem[0x31] hold the new data and mem[0x32],mem[0x33] keep their old values.
- Alignment: read at req_addr=0x00000017. Required: DRAM addresses 0x14..0x17 driven in order.

Source files
------------

// File: rtl/dram_line_adapter.sv
// rtl/dram_line_adapter.sv - cache-line to single-word DRAM burst bridge
module dram_line_adapter #(
  parameter int DATA  = 32,
  parameter int ADDR  = 32,
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR-1:0]       req_addr,
  input  logic [DATA*WORDS-1:0] req_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_wr,
  output logic [DATA*WORDS-1:0] resp_data,
  output logic                  mem_wr,
  output logic [ADDR-1:0]       mem_addr,
  output logic [DATA-1:0]       mem_din,
  input  logic [DATA-1:0]       mem_dout
);
  localparam int CW = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, BURST, CAPTURE, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR-1:0]       base_q, base_d;
  logic                  wr_q, wr_d;
  logic [DATA*WORDS-1:0] wbuf_q, wbuf_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  cap_en_q, cap_en_d;
  logic [CW-1:0]         cap_idx_q, cap_idx_d;
  logic [DATA*WORDS-1:0] rbuf_q, rbuf_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      base_q    <= '0;
      wr_q      <= 1'b0;
      wbuf_q    <= '0;
      cnt_q     <= '0;
      cap_en_q  <= 1'b0;
      cap_idx_q <= '0;
      rbuf_q    <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      wr_q      <= wr_d;
      wbuf_q    <= wbuf_d;
      cnt_q     <= cnt_d;
      cap_en_q  <= cap_en_d;
      cap_idx_q <= cap_idx_d;
      rbuf_q    <= rbuf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    wr_d      = wr_q;
    wbuf_d    = wbuf_q;
    cnt_d     = cnt_q;
    cap_en_d  = 1'b0;
    cap_idx_d = cap_idx_q;
    rbuf_d    = rbuf_q;

    // DRAM read data lags the address by one cycle, so capture runs one beat behind.
    if (cap_en_q)
      rbuf_d[int'(cap_idx_q)*DATA +: DATA] = mem_dout;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          base_d  = req_addr & ~ADDR'(WORDS-1);
          wr_d    = req_wr;
          wbuf_d  = req_data;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        cap_en_d  = 1'b1;
        cap_idx_d = cnt_q;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CW'(WORDS-1))
          state_d = CAPTURE;
      end
      CAPTURE: state_d = RESP;
      RESP: begin
        if (resp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_wr    = wr_q;
  assign resp_data  = rbuf_q;
  assign mem_wr     = (state_q == BURST) && wr_q;
  assign mem_addr   = base_q + ADDR'(cnt_q);
  assign mem_din    = wbuf_q[int'(cnt_q)*DATA +: DATA];
endmodule

// File: tb/tb_dram_line_adapter.sv
// tb/tb_dram_line_adapter.sv - randomized self-checking bench for dram_line_adapter
module tb_dram_line_adapter;
  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_ready, req_wr;
  logic [31:0]  req_addr;
  logic [127:0] req_data;
  logic         resp_valid, resp_ready, resp_wr;
  logic [127:0] resp_data;
  logic         mem_wr;
  logic [31:0]  mem_addr, mem_din, mem_dout;

  logic         preload;
  logic [31:0]  dram    [0:255];
  logic [31:0]  ref_mem [0:255];
  int           n_checks = 0;
  int           n_pass   = 0;

  dram_line_adapter #(.DATA(32), .ADDR(32), .WORDS(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_wr(resp_wr),
    .resp_data(resp_data),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Single-port word DRAM: registered read, write-through echo on dout.
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 256; k++) dram[k] <= 32'hA000_0000 + k;
    end else if (mem_wr) begin
      dram[mem_addr[7:0]] <= mem_din;
    end
    mem_dout <= mem_wr ? mem_din : dram[mem_addr[7:0]];
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Starts at a negedge with the DUT idle; ends at the negedge after the response handshake.
  task automatic run_req(input logic wr, input logic [31:0] addr, input logic [127:0] data,
                         input int stall, input logic hold, output logic [127:0] line);
    logic [31:0]  base;
    logic [127:0] exp;
    logic [7:0]   idx;
    base = addr & ~32'h3;
    for (int i = 0; i < 4; i++) begin
      idx = base[7:0] + 8'(i);
      if (wr) begin
        exp[i*32 +: 32] = data[i*32 +: 32];
        ref_mem[idx]    = data[i*32 +: 32];
      end else begin
        exp[i*32 +: 32] = ref_mem[idx];
      end
    end
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_data = data;
    check("req_ready_idle", req_ready, 1'b1);
    @(posedge clk);
    #1 if (!hold) req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("beat_addr", mem_addr, base + i);
      check("beat_wr", mem_wr, wr);
      if (wr) check("beat_din", mem_din, data[i*32 +: 32]);
      check("busy_req_ready", req_ready, 1'b0);
      check("busy_resp_valid", resp_valid, 1'b0);
    end
    @(negedge clk);
    check("capture_resp_valid", resp_valid, 1'b0);
    check("capture_mem_wr", mem_wr, 1'b0);
    @(negedge clk);
    check("resp_latency", resp_valid, 1'b1);
    check("resp_data", resp_data, exp);
    check("resp_wr", resp_wr, wr);
    check("resp_req_ready", req_ready, 1'b0);
    line = resp_data;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", resp_valid, 1'b1);
      check("stall_data", resp_data, exp);
      check("stall_wr", resp_wr, wr);
      check("stall_req_ready", req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check("post_hs_resp_valid", resp_valid, 1'b0);
    check("post_hs_req_ready", req_ready, 1'b1);
    check("post_hs_mem_wr", mem_wr, 1'b0);
  endtask

  initial begin
    logic [127:0] line, wline, rline;
    reset = 1'b1; preload = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_data = '0; resp_ready = 1'b0;
    for (int k = 0; k < 256; k++) ref_mem[k] = 32'hA000_0000 + k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_wr", resp_wr, 1'b0);
    check("rst_resp_data", resp_data, 128'h0);
    check("rst_mem_wr", mem_wr, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_din", mem_din, 32'h0);
    reset = 1'b0; preload = 1'b0;
    @(negedge clk);

    run_req(1'b0, 32'h0000_000B, '0, 0, 1'b0, line);
    check("read_const", line, 128'hA000000B_A000000A_A0000009_A0000008);

    wline = 128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000;
    run_req(1'b1, 32'h10, wline, 0, 1'b0, line);
    check("write_echo", line, wline);
    run_req(1'b0, 32'h10, '0, 1, 1'b0, line);
    check("write_readback", line, wline);

    run_req(1'b0, 32'h08, '0, 10, 1'b0, line);

    run_req(1'b0, 32'h20, '0, 2, 1'b1, line);
    run_req(1'b1, 32'h24, 128'h11112222_33334444_55556666_77778888, 0, 1'b0, line);

    run_req(1'b0, 32'h17, '0, 0, 1'b0, line);

    wline = 128'hBEEF0003_BEEF0002_BEEF0001_BEEF0000;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h30; req_data = wline;
    check("rst_test_ready", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_mem_wr", mem_wr, 1'b0);
    check("midrst_resp_valid", resp_valid, 1'b0);
    check("midrst_req_ready", req_ready, 1'b1);
    ref_mem[8'h30] = wline[31:0];
    ref_mem[8'h31] = wline[63:32];
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) check("midrst_dram", dram[8'h30 + k], ref_mem[8'h30 + k]);
    @(negedge clk);
    run_req(1'b0, 32'h30, '0, 0, 1'b0, line);

    for (int t = 0; t < 12; t++) begin
      rline = {$urandom, $urandom, $urandom, $urandom};
      run_req(1'($urandom_range(0, 1)), 32'($urandom_range(64, 255)), rline,
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), line);
      req_valid = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
